// File: rtl/l1c_pkg.sv
// l1c_pkg: shared types, access-size encodings, byte-enable and tree-PLRU helpers for the L1 data cache
package l1c_pkg;
  localparam int CACHE_TYPE_BITS = 2;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE  = 2'd0;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HWORD = 2'd1;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_WORD  = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_UC_RD, S_WR} state_t;
  function automatic logic [3:0] byte_en(input logic [CACHE_TYPE_BITS-1:0] t, input logic [1:0] a);
    return t == CACHE_BYTE ? 4'b0001 << a : t == CACHE_HWORD ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic int plru_levels(input int ways);
    return ways >= 8 ? 3 : ways >= 4 ? 2 : ways >= 2 ? 1 : 0;
  endfunction
  // Heap-ordered tree: node n has children 2n+1/2n+2; a 0 bit steers the victim to the left subtree.
  function automatic logic [6:0] plru_update(input logic [6:0] bits, input int ways, input logic [2:0] way);
    logic [6:0] r;
    int n, lv;
    r = bits;
    n = 0;
    lv = plru_levels(ways);
    for (int i = 0; i < 3; i++)
      if (i < lv) begin
        r[n] = !way[lv-1-i];
        n = 2 * n + 1 + int'(way[lv-1-i]);
      end
    return r;
  endfunction
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int ways);
    logic [2:0] v;
    int n, lv;
    v = '0;
    n = 0;
    lv = plru_levels(ways);
    for (int i = 0; i < 3; i++)
      if (i < lv) begin
        v = {v[1:0], bits[n]};
        n = 2 * n + 1 + int'(bits[n]);
      end
    return v;
  endfunction
endpackage

// File: rtl/l1c_data_assoc_way_array.sv
// l1c_way_array: one cache way's flop-based tag, valid and line storage with byte-masked word writes
module l1c_way_array #(
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(SETS)-1:0]       idx,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] ofs,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    be,
  input  logic                          tag_we,
  input  logic [TAG_W-1:0]              tag_in,
  input  logic                          set_valid,
  input  logic                          clr,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [LINE_WORDS*32-1:0]      rd_line
);
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [LINE_WORDS*32-1:0] data [SETS];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (clr) valid[idx] <= 1'b0;
    else if (set_valid) valid[idx] <= 1'b1;
  always_ff @(posedge clk) begin
    if (tag_we) tags[idx] <= tag_in;
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) data[idx][32*int'(ofs) + 8*b +: 8] <= wdata[8*b +: 8];
  end
  assign rd_valid = valid[idx];
  assign rd_tag = tags[idx];
  assign rd_line = data[idx];
endmodule

// File: rtl/l1c_data_assoc.sv
// l1c_data_assoc: N-way write-through, no-write-allocate L1 data cache with tree-PLRU and an uncacheable window
// Defining L1C_PERF_CNT_EN adds read/write hit/miss counter ports.
module l1c_data_assoc
  import l1c_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4,
  parameter logic [31:0] UC_BASE = 32'h1000_0000,
  parameter logic [31:0] UC_MASK = 32'hFFFF_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_req,
  input  logic                       core_write,
  input  logic [31:0]                core_addr,
  input  logic [31:0]                core_in,
  input  logic [CACHE_TYPE_BITS-1:0] core_type,
  output logic [31:0]                core_out,
  output logic                       core_wait,
  output logic                       D_req,
  output logic [31:0]                D_addr,
  output logic                       D_write,
  output logic [31:0]                D_in,
  output logic [CACHE_TYPE_BITS-1:0] D_type,
  input  logic [31:0]                D_out,
  input  logic                       D_wait
`ifdef L1C_PERF_CNT_EN
  ,
  output logic [31:0]                rd_hit_cnt,
  output logic [31:0]                rd_miss_cnt,
  output logic [31:0]                wr_hit_cnt,
  output logic [31:0]                wr_miss_cnt
`endif
);
  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFS_W - 2;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int PW = WAYS > 1 ? WAYS - 1 : 1;
  state_t state;
  logic [OFS_W-1:0] beat, ofs, wofs;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WW-1:0] vic, vic_r, hit_way, hit_way_r, plru_vic, plru_way;
  logic hit, lhit, hit_r, uc, ld_hit, done, refill_wr, refill_last, store_wr, alloc, plru_upd;
  logic [31:0] hit_word, wdata;
  logic [3:0] wbe;
  logic rd_valid [WAYS];
  logic [TAG_W-1:0] rd_tag [WAYS];
  logic [LINE_WORDS*32-1:0] rd_line [WAYS];
  assign ofs = core_addr[OFS_W+1:2];
  assign idx = core_addr[IDX_W+OFS_W+1:OFS_W+2];
  assign tag = core_addr[31:IDX_W+OFS_W+2];
  assign uc = (core_addr & UC_MASK) == UC_BASE;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    hit_word = '0;
    vic = plru_vic;
    for (int w = 0; w < WAYS; w++)
      if (rd_valid[w] && rd_tag[w] == tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
        hit_word = rd_line[w][32*int'(ofs) +: 32];
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!rd_valid[w]) vic = WW'(w);
  end
  assign lhit = hit && !uc;
  assign ld_hit = state == S_LOOKUP && !core_write && lhit;
  assign refill_wr = state == S_REFILL && !D_wait;
  assign refill_last = refill_wr && &beat;
  assign store_wr = state == S_WR && !D_wait && hit_r;
  assign alloc = state == S_LOOKUP && !core_write && !uc && !hit;
  assign wofs = state == S_REFILL ? beat : ofs;
  assign wdata = state == S_REFILL ? D_out : core_in;
  assign wbe = state == S_REFILL ? 4'hF : byte_en(core_type, core_addr[1:0]);
  assign plru_upd = ld_hit || store_wr;
  assign plru_way = state == S_WR ? hit_way_r : hit_way;
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l1c_way_array #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way (
      .clk(clk),
      .rst(rst),
      .idx(idx),
      .we((refill_wr && vic_r == WW'(g)) || (store_wr && hit_way_r == WW'(g))),
      .ofs(wofs),
      .wdata(wdata),
      .be(wbe),
      .tag_we(refill_last && vic_r == WW'(g)),
      .tag_in(tag),
      .set_valid(refill_last && vic_r == WW'(g)),
      .clr(alloc && vic == WW'(g)),
      .rd_valid(rd_valid[g]),
      .rd_tag(rd_tag[g]),
      .rd_line(rd_line[g])
    );
  end
  if (WAYS > 1) begin : g_plru
    logic [SETS-1:0][PW-1:0] plru;
    always_ff @(posedge clk or posedge rst)
      if (rst) plru <= '0;
      else if (plru_upd) plru[idx] <= PW'(plru_update(7'(plru[idx]), WAYS, 3'(plru_way)));
    assign plru_vic = WW'(plru_victim(7'(plru[idx]), WAYS));
  end else begin : g_noplru
    assign plru_vic = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      beat <= '0;
      vic_r <= '0;
      hit_r <= 1'b0;
      hit_way_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (core_req) state <= S_LOOKUP;
        S_LOOKUP: begin
          hit_r <= lhit;
          hit_way_r <= hit_way;
          vic_r <= vic;
          beat <= '0;
          state <= core_write ? S_WR : uc ? S_UC_RD : hit ? S_IDLE : S_REFILL;
        end
        S_REFILL:
          if (!D_wait) begin
            beat <= beat + 1'b1;
            if (&beat) state <= S_LOOKUP;
          end
        S_UC_RD, S_WR: if (!D_wait) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  assign done = ld_hit || ((state == S_UC_RD || state == S_WR) && !D_wait);
  assign core_wait = !done;
  assign core_out = ld_hit ? hit_word : (state == S_UC_RD && !D_wait) ? D_out : '0;
  assign D_req = state == S_REFILL || state == S_UC_RD || state == S_WR;
  assign D_addr = state == S_REFILL ? {core_addr[31:OFS_W+2], beat, 2'b00} : D_req ? core_addr : '0;
  assign D_write = state == S_WR;
  assign D_in = D_write ? core_in : '0;
  assign D_type = (state == S_UC_RD || state == S_WR) ? core_type : CACHE_WORD;
`ifdef L1C_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_hit_cnt <= '0;
      rd_miss_cnt <= '0;
      wr_hit_cnt <= '0;
      wr_miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      rd_hit_cnt <= rd_hit_cnt + 32'(!core_write && lhit);
      rd_miss_cnt <= rd_miss_cnt + 32'(!core_write && !lhit);
      wr_hit_cnt <= wr_hit_cnt + 32'(core_write && lhit);
      wr_miss_cnt <= wr_miss_cnt + 32'(core_write && !lhit);
    end
`endif
endmodule

// File: doc/l1c_data_assoc.md
Name: l1c_data_assoc

Overview:
- Parametrised N-way set-associative L1 data cache between the CPU core and the CPU wrapper memory port.
- Write-through, no-write-allocate, tree-PLRU replacement, configurable sets and line length.
- Adds a parametrised uncacheable window that bypasses the cache.
- Tag/data/valid storage is flop-based inside the block; no SRAM wrappers.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, >=2.
- UC_BASE, 32'h1000_0000, base of the uncacheable window.
- UC_MASK, 32'hFFFF_0000, address bits compared against UC_BASE.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- core_req  input  1  access request; held with all core_* inputs stable until core_wait=0
- core_write  input  1  1=store, 0=load
- core_addr  input  32  byte address
- core_in  input  32  store data, already lane-aligned to core_addr[1:0]
- core_type  input  CACHE_TYPE_BITS  CACHE_BYTE/CACHE_HWORD/CACHE_WORD
- core_out  output  32  load data; valid only in the completion cycle, else 0
- core_wait  output  1  0 for exactly one completion cycle per access, else 1
- D_req  output  1  memory beat request
- D_addr  output  32  beat address
- D_write  output  1  memory write
- D_in  output  32  memory write data
- D_type  output  CACHE_TYPE_BITS  access size (CACHE_WORD on refill beats)
- D_out  input  32  memory read data, valid when D_wait=0
- D_wait  input  1  1=beat not yet accepted

Behaviour:
- Address split: offset = addr[OFS_W+1:2], where OFS_W = log2(LINE_WORDS); index = next log2(SETS) bits; tag = remaining upper bits.
- uc = ((core_addr & UC_MASK) == UC_BASE).
- Reset: state IDLE; all valid bits and PLRU bits cleared; core_wait=1; core_out, D_req, D_addr, D_write, D_in = 0. Reset mid-refill abandons the line, which stays invalid.
- States and transitions:
  - IDLE: core_req moves to LOOKUP.
  - LOOKUP: hit = any way valid with tag match; at most one way may hit.
    - Load hit: core_out = matching word; core_wait=0; PLRU updated toward the hit way; go to IDLE. Load hit latency is 2 cycles from request.
    - Load miss, !uc: go to REFILL.
    - Load, uc: go to UC_RD; uc addresses are never allocated.
    - Store (hit, miss or uc): go to WR.
  - REFILL: LINE_WORDS beats, word 0 first. Beat k: D_req=1, D_addr = {tag, index, k, 2'b00}, D_write=0.
    - Each beat with D_wait=0 writes D_out into word k of the victim way.
    - After the last beat: set valid, write the tag, return to LOOKUP. The retry hits.
    - Victim selection: lowest-index invalid way, else the PLRU way.
  - UC_RD: D_req=1, D_addr=core_addr. When D_wait=0: core_out=D_out, core_wait=0, go to IDLE.
  - WR: D_req=1, D_write=1, D_addr=core_addr, D_in=core_in, D_type=core_type.
    - When D_wait=0: core_wait=0, go to IDLE.
    - If the LOOKUP was a hit, the same cycle merges core_in into the hit word using byte enables from core_type and core_addr[1:0], and updates PLRU.
- Byte enables (active-high): BYTE gives 1<<addr[1:0]; HWORD gives 0011 or 1100 selected by addr[1]; WORD gives 1111.
- WAYS=1: PLRU logic is absent; the victim is always way 0.
- core_req dropping before completion is illegal. The bench flags it; behaviour is undefined.

Optional Feature:
- Macro L1C_PERF_CNT_EN.
- When defined: 32-bit output ports rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt are added. Each increments once per LOOKUP outcome; uc accesses count as misses. Counters wrap at 2^32 and are cleared by rst.
- When undefined: the ports and counters are absent; function is otherwise identical.

Decomposition:
- Package l1c_pkg:
  - state enum;
  - function byte_en(type, addr[1:0]);
  - PLRU update and victim functions parametrised on WAYS;
  - CACHE_TYPE encodings, re-exported from def.svh.
- Sub-module l1c_way_array: one way's tag, valid and data storage. Parameters SETS, LINE_WORDS, TAG_W. Ports: read index, word write with byte mask, tag write, valid set, sync clear. Instantiated WAYS times in a generate loop.

Test Plan:
- Cold load 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 over 4 beats, D_wait=1 for 2 cycles per beat → D_addr steps 0x40,0x44,0x48,0x4C. Retry hits; core_out=0x11. A following load of 0x4C completes in 2 cycles with 0x44 and no D_req.
- WAYS=2: load 0x000, 0x400, 0x000, then 0x800 (same index) → 0x400's line is evicted. Load 0x000 hits; load 0x400 misses.
- Store byte 0xAB (core_in=0x00AB0000, addr 0x42) to a cached line holding 0x11223344 → D_write beat with D_type=BYTE. A later load of 0x40 returns 0x11AB3344.
- Store miss to 0x2000 → exactly one D_req beat, no refill. A following load of 0x2000 misses.
- Load 0x1000_0004 (uc) twice → two single-beat D_req; core_out tracks D_out (0xDEAD, then 0xBEEF). Never a hit.
- Assert rst during refill beat 2, then load the same address → full 4-beat refill reissued from word 0. With L1C_PERF_CNT_EN defined, all counters read 0 after reset.
